// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl: opens a vote round on start_i, collects one vote per
// voter (first vote wins), decides a strict majority over WIDTH_IN voters and
// presents the registered decision on a valid/ready handshake.
// Optional: define MAJ_CTRL_TIMEOUT_EN to force a decision after TIMEOUT
// cycles in COLLECT; otherwise COLLECT waits for every voter.
module majority_vote_ctrl #(
  parameter int WIDTH_IN = 5,
  parameter int TIMEOUT  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [WIDTH_IN-1:0]            vote_valid_i,
  input  logic [WIDTH_IN-1:0]            vote_i,
  output logic                           busy_o,
  output logic [WIDTH_IN-1:0]            voted_mask_o,
  output logic                           result_valid_o,
  input  logic                           result_ready_i,
  output logic                           result_o,
  output logic [$clog2(WIDTH_IN+1)-1:0]  yes_cnt_o,
  output logic                           timeout_o
);

  localparam int CNT_W = $clog2(WIDTH_IN + 1);
  localparam logic [CNT_W-1:0] MAJ_THRESH = CNT_W'(WIDTH_IN / 2 + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH_IN-1:0] vote_q, vote_d;
  logic [WIDTH_IN-1:0] mask_q, mask_d;
  logic                result_q, result_d;
  logic [CNT_W-1:0]    yes_q, yes_d;
  logic                to_q, to_d;
  logic [WIDTH_IN-1:0] accept;
  logic [CNT_W-1:0]    yes_now;

`ifdef MAJ_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer_q, timer_d;
`endif

  // Zero-extended population count; the result width always holds WIDTH_IN.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH_IN-1:0] bits);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      sum = sum + CNT_W'(bits[i]);
    end
    return sum;
  endfunction

  // Next-state and datapath update for the round sequencer.
  always_comb begin
    state_d  = state_q;
    vote_d   = vote_q;
    mask_d   = mask_q;
    result_d = result_q;
    yes_d    = yes_q;
    to_d     = to_q;
`ifdef MAJ_CTRL_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    // Only voters not yet counted may latch a vote (first vote wins).
    accept   = vote_valid_i & ~mask_q;
    yes_now  = popcount(vote_q & mask_q);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          vote_d   = '0;
          mask_d   = '0;
          result_d = 1'b0;
          yes_d    = '0;
          to_d     = 1'b0;
`ifdef MAJ_CTRL_TIMEOUT_EN
          timer_d  = '0;
`endif
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        vote_d = vote_q | (vote_i & accept);
        mask_d = mask_q | accept;
        if (&mask_d) begin
          state_d = S_DECIDE;
        end
`ifdef MAJ_CTRL_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DECIDE;
        end
        timer_d = timer_q + 1'b1;
`endif
      end
      S_DECIDE: begin
        yes_d    = yes_now;
        result_d = (yes_now >= MAJ_THRESH);
`ifdef MAJ_CTRL_TIMEOUT_EN
        // A partial mask here can only mean the timer closed the round.
        to_d     = ~(&mask_q);
`else
        to_d     = 1'b0;
`endif
        state_d  = S_RESULT;
      end
      S_RESULT: begin
        if (result_ready_i) begin
          if (start_i) begin
            vote_d   = '0;
            mask_d   = '0;
            result_d = 1'b0;
            yes_d    = '0;
            to_d     = 1'b0;
`ifdef MAJ_CTRL_TIMEOUT_EN
            timer_d  = '0;
`endif
            state_d  = S_COLLECT;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vote_q   <= '0;
      mask_q   <= '0;
      result_q <= 1'b0;
      yes_q    <= '0;
      to_q     <= 1'b0;
`ifdef MAJ_CTRL_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vote_q   <= vote_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      yes_q    <= yes_d;
      to_q     <= to_d;
`ifdef MAJ_CTRL_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = (state_q == S_RESULT);
  assign voted_mask_o   = mask_q;
  assign result_o       = result_q;
  assign yes_cnt_o      = yes_q;
  assign timeout_o      = to_q;

endmodule
